// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with registered one-hot grant and a fixed turnaround gap between owners.
// Optional per-owner watchdog with a mask on the offender, enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
  parameter int N          = 4,
  parameter int IDW        = 2,
  parameter int TURNAROUND = 1,
  parameter int TIMEOUT    = 255,
  parameter int TOW        = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;
  logic [3:0]     turn_q, turn_d;
  logic           to_q, to_d;
  logic [N-1:0]   elig;
  logic [IDW-1:0] win;
  logic           win_vld;

`ifdef ARB_TIMEOUT_EN
  logic [TOW-1:0] tcnt_q, tcnt_d;
  logic [N-1:0]   mask_q, mask_d;
  logic           expire;

  // Fires on the last allowed GRANT cycle, so the owner holds exactly TIMEOUT cycles.
  assign expire = (tcnt_q == TOW'(TIMEOUT - 1));
  assign elig   = req & ~mask_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^{TIMEOUT[0], TOW[0]};
  assign elig       = req;
`endif

  // Rotating search starting just after the last owner.
  always_comb begin
    logic [IDW-1:0] cand;
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDW'((int'(last_q) + i) % N);
      if (!win_vld && elig[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    turn_d  = turn_q;
    to_d    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    mask_d  = mask_q & req;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          id_d         = win;
          last_d       = win;
          state_d      = GRANT;
`ifdef ARB_TIMEOUT_EN
          tcnt_d       = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[id_q]) begin
          grant_d = '0;
          turn_d  = '0;
          state_d = TURN;
`ifdef ARB_TIMEOUT_EN
        end else if (expire) begin
          grant_d      = '0;
          turn_d       = '0;
          state_d      = TURN;
          to_d         = 1'b1;
          mask_d[id_q] = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
`endif
        end
      end
      TURN: begin
        if (turn_q == 4'(TURNAROUND - 1)) state_d = IDLE;
        else                              turn_d  = turn_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= IDW'(N - 1);
      turn_q  <= '0;
      to_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tcnt_q  <= '0;
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      turn_q  <= turn_d;
      to_q    <= to_d;
`ifdef ARB_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      mask_q  <= mask_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign gnt_id  = id_q;
  assign busy    = |grant_q;
  assign timeout = to_q;

endmodule
